// File: rtl/cpu_mem_arbiter.sv
// Two-master (fetch/data) to single-port memory arbiter with one transaction in flight.
// Data wins by default; a streak counter forces a fetch grant after STREAK_MAX data grants.

module cpu_mem_arbiter_chk (
   input  logic clk,
   input  logic reset,
   input  logic idle_s,
   input  logic inst_addr_ok,
   input  logic data_addr_ok,
   input  logic inst_data_ok,
   input  logic data_data_ok
);

   // Handshake sanity: one accept per cycle, only from IDLE, one response per cycle.
   always @(posedge clk) begin
      if (!reset) begin
         a_one_addr_ok : assert (!(inst_addr_ok && data_addr_ok));
         a_addr_ok_idle : assert (idle_s || !(inst_addr_ok || data_addr_ok));
         a_one_data_ok : assert (!(inst_data_ok && data_data_ok));
      end
   end

endmodule

module cpu_mem_arbiter #(
   parameter int unsigned STREAK_MAX = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(STREAK_MAX);
   localparam logic [CNT_W-1:0] STREAK_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] streak_q, streak_d;
   logic             owner_q, owner_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_wr_q, mem_wr_d;
   logic [3:0]       mem_wstrb_q, mem_wstrb_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [31:0]      inst_rdata_q, inst_rdata_d;
   logic [31:0]      data_rdata_q, data_rdata_d;
   logic             inst_data_ok_q, inst_data_ok_d;
   logic             data_data_ok_q, data_data_ok_d;

   logic             idle_s;
   logic             streak_full_s;
   logic             pick_data_s;
   logic             grant_s;
   logic             resp_s;

   // Arbitration decision and the combinational accept strobes.
   always_comb begin
      idle_s        = (state_q == IDLE);
      streak_full_s = (streak_q == STREAK_LIM);
      pick_data_s   = data_req && !(inst_req && streak_full_s);
      // reset gates the accept so a master never sees a handshake that the flops then discard
      grant_s       = idle_s && !reset && (inst_req || data_req);
      data_addr_ok  = grant_s && pick_data_s;
      inst_addr_ok  = grant_s && !pick_data_s;
   end

   // Next-state, latched request fields, streak and response capture.
   always_comb begin
      state_d        = state_q;
      streak_d       = streak_q;
      owner_d        = owner_q;
      mem_req_d      = mem_req_q;
      mem_wr_d       = mem_wr_q;
      mem_wstrb_d    = mem_wstrb_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      inst_rdata_d   = inst_rdata_q;
      data_rdata_d   = data_rdata_q;
      inst_data_ok_d = 1'b0;
      data_data_ok_d = 1'b0;
      resp_s         = 1'b0;

      case (state_q)
         IDLE: begin
            if (inst_req || data_req) begin
               state_d   = REQ;
               mem_req_d = 1'b1;
               owner_d   = pick_data_s;
               if (pick_data_s) begin
                  mem_wr_d    = data_wr;
                  mem_wstrb_d = data_wstrb;
                  mem_addr_d  = data_addr;
                  mem_wdata_d = data_wdata;
                  if (!inst_req) begin
                     streak_d = {CNT_W{1'b0}};
                  end else if (streak_full_s) begin
                     streak_d = streak_q;
                  end else begin
                     streak_d = streak_q + STREAK_ONE;
                  end
               end else begin
                  mem_wr_d    = 1'b0;
                  mem_wstrb_d = 4'b0000;
                  mem_addr_d  = inst_addr;
                  mem_wdata_d = 32'h0000_0000;
                  streak_d    = {CNT_W{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_addr_ok) begin
               mem_req_d = 1'b0;
               // a memory that answers in the accept cycle skips WAIT entirely
               if (mem_data_ok) begin
                  resp_s  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (mem_data_ok) begin
               resp_s  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (resp_s) begin
         if (owner_q) begin
            data_rdata_d   = mem_rdata;
            data_data_ok_d = 1'b1;
         end else begin
            inst_rdata_d   = mem_rdata;
            inst_data_ok_d = 1'b1;
         end
      end else begin
         inst_rdata_d = inst_rdata_d;
      end
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         streak_q       <= {CNT_W{1'b0}};
         owner_q        <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_wr_q       <= 1'b0;
         mem_wstrb_q    <= 4'b0000;
         mem_addr_q     <= 32'h0000_0000;
         mem_wdata_q    <= 32'h0000_0000;
         inst_rdata_q   <= 32'h0000_0000;
         data_rdata_q   <= 32'h0000_0000;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         streak_q       <= streak_d;
         owner_q        <= owner_d;
         mem_req_q      <= mem_req_d;
         mem_wr_q       <= mem_wr_d;
         mem_wstrb_q    <= mem_wstrb_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         inst_rdata_q   <= inst_rdata_d;
         data_rdata_q   <= data_rdata_d;
         inst_data_ok_q <= inst_data_ok_d;
         data_data_ok_q <= data_data_ok_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_wr       = mem_wr_q;
   assign mem_wstrb    = mem_wstrb_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;
   assign inst_data_ok = inst_data_ok_q;
   assign data_data_ok = data_data_ok_q;

   cpu_mem_arbiter_chk u_chk (
      .clk          (clk),
      .reset        (reset),
      .idle_s       (idle_s),
      .inst_addr_ok (inst_addr_ok),
      .data_addr_ok (data_addr_ok),
      .inst_data_ok (inst_data_ok),
      .data_data_ok (data_data_ok)
   );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: vector table of single transactions plus
// hand-written multi-cycle sequences (contention, streak, stalls, reset, fast memory).

module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic        auto_mem = 1'b0;
   logic        pend     = 1'b0;
   logic [31:0] auto_rdata = 32'h0000_00AA;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(.STREAK_MAX(4), .CNT_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   typedef struct {
      logic        is_data;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_rd;
      logic        exp_wr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Zero-wait memory model: accept whenever asked, answer the following cycle.
   task automatic step_mem();
      if (auto_mem) begin
         mem_data_ok = pend;
         mem_rdata   = auto_rdata;
         mem_addr_ok = mem_req;
         pend        = mem_req;
      end
   endtask

   task automatic mem_off();
      auto_mem    = 1'b0;
      pend        = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
   endtask

   logic [31:0] last_inst_rd = 32'h0;
   logic [31:0] last_data_rd = 32'h0;

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      next_cycle();
      if (v.is_data) begin
         data_req = 1'b1; data_wr = v.wr; data_wstrb = v.wstrb;
         data_addr = v.addr; data_wdata = v.wdata;
      end else begin
         inst_req = 1'b1; inst_addr = v.addr;
         data_wr = 1'b1; data_wstrb = 4'hF; data_wdata = 32'hFFFF_FFFF;
      end
      sample();
      chk({tag, "_data_addr_ok"}, data_addr_ok, v.is_data);
      chk({tag, "_inst_addr_ok"}, inst_addr_ok, !v.is_data);
      chk({tag, "_mem_req_c0"}, mem_req, 1'b0);
      next_cycle();
      data_req = 1'b0; inst_req = 1'b0;
      data_addr = ~v.addr; inst_addr = ~v.addr; data_wdata = ~v.wdata; data_wstrb = ~v.wstrb;
      mem_addr_ok = 1'b1;
      sample();
      chk({tag, "_mem_req_c1"}, mem_req, 1'b1);
      chk({tag, "_mem_addr"}, mem_addr, v.addr);
      chk({tag, "_mem_wr"}, mem_wr, v.exp_wr);
      chk({tag, "_mem_wstrb"}, mem_wstrb, v.exp_wstrb);
      if (v.exp_wr) chk({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
      next_cycle();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = v.mem_rd;
      sample();
      chk({tag, "_mem_req_c2"}, mem_req, 1'b0);
      chk({tag, "_data_ok_c2"}, v.is_data ? data_data_ok : inst_data_ok, 1'b0);
      next_cycle();
      mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_0000;
      sample();
      if (v.is_data) last_data_rd = v.exp_rdata; else last_inst_rd = v.exp_rdata;
      chk({tag, "_inst_data_ok_c3"}, inst_data_ok, !v.is_data);
      chk({tag, "_data_data_ok_c3"}, data_data_ok, v.is_data);
      chk({tag, "_inst_rdata"}, inst_rdata, last_inst_rd);
      chk({tag, "_data_rdata"}, data_rdata, last_data_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      int   order [8];
      int   exp_order [6];
      int   ng;
      int   d_grant_c, i_grant_c, d_ok_c, i_ok_c;
      logic drop_d, drop_i;

      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 1'b0, 4'h0, 32'h0, 32'h3C08_0001};
      vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h8000_1000, 32'h0, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 32'h1122_3344};
      vecs[2] = '{1'b1, 1'b1, 4'hC, 32'h8000_2004, 32'h55AA_0FF0, 32'h0000_0000, 1'b1, 4'hC, 32'h55AA_0FF0, 32'h0000_0000};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, 32'h2409_0002, 1'b0, 4'h0, 32'h0, 32'h2409_0002};
      vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h8C01_0000, 1'b0, 4'h0, 32'h0, 32'h8C01_0000};

      reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
      data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
      repeat (3) next_cycle();
      inst_req = 1'b1; data_req = 1'b1;
      sample();
      chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
      chk("rst_data_addr_ok", data_addr_ok, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_inst_rdata", inst_rdata, 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      next_cycle();
      reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;

      // stray response while idle is ignored
      mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
      sample();
      next_cycle();
      mem_data_ok = 1'b0;
      sample();
      chk("idle_stray_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      chk("idle_stray_rdata", inst_rdata | data_rdata, 32'h0);
      chk("idle_stray_mem_req", mem_req, 1'b0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // contention: data first, fetch granted in the cycle data completes
      next_cycle();
      auto_mem = 1'b1; pend = 1'b0; ng = 0; drop_d = 1'b0; drop_i = 1'b0;
      d_grant_c = -1; i_grant_c = -1; d_ok_c = -1; i_ok_c = -1;
      for (int i = 0; i < 8; i++) order[i] = -1;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) next_cycle();
         step_mem();
         if (c == 0) begin
            data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h8000_1000;
            inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
         end
         if (drop_d) data_req = 1'b0;
         if (drop_i) inst_req = 1'b0;
         sample();
         if (data_addr_ok) begin order[ng] = 0; ng++; d_grant_c = c; drop_d = 1'b1; end
         if (inst_addr_ok) begin order[ng] = 1; ng++; i_grant_c = c; drop_i = 1'b1; end
         if (c == 1) chk("t2_mem_addr", mem_addr, 32'h8000_1000);
         if (data_data_ok) d_ok_c = c;
         if (inst_data_ok) begin i_ok_c = c; break; end
      end
      chk("t2_first_grant", order[0], 0);
      chk("t2_second_grant", order[1], 1);
      chk("t2_data_grant_cycle", d_grant_c, 0);
      chk("t2_data_ok_cycle", d_ok_c, 3);
      chk("t2_inst_grant_cycle", i_grant_c, 3);
      chk("t2_inst_ok_cycle", i_ok_c, 6);
      chk("t2_data_rdata", data_rdata, 32'h0000_00AA);

      // streak: both held; four data grants, one fetch, data again
      exp_order = '{0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) order[i] = -1;
      ng = 0; i_grant_c = -100;
      for (int c = 0; c < 60; c++) begin
         next_cycle();
         step_mem();
         if (c == 0) begin
            data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h8000_3000;
            data_wdata = 32'h0000_0001; inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
         end
         sample();
         if (c == i_grant_c + 1) begin
            chk("t3_inst_mem_wr", mem_wr, 1'b0);
            chk("t3_inst_mem_wstrb", mem_wstrb, 4'h0);
            chk("t3_inst_mem_addr", mem_addr, 32'hBFC0_0200);
         end
         if (data_addr_ok) begin order[ng] = 0; ng++; end
         if (inst_addr_ok) begin order[ng] = 1; ng++; i_grant_c = c; end
         if (ng >= 6) break;
      end
      chk("t3_grant_count", ng, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), order[i], exp_order[i]);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         step_mem();
         data_req = 1'b0; inst_req = 1'b0;
         sample();
      end
      mem_off();

      // store with delayed accept and a stray early response
      next_cycle();
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
      data_addr = 32'h8000_5008; data_wdata = 32'hDEAD_BEEF;
      sample();
      chk("t4_addr_ok", data_addr_ok, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 1) begin
            data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h0; data_wdata = 32'h0;
         end
         mem_addr_ok = (k == 4);
         mem_data_ok = (k == 2);
         mem_rdata = (k == 2) ? 32'h0BAD_0BAD : 32'h0;
         sample();
         chk($sformatf("t4_mem_req_k%0d", k), mem_req, 1'b1);
         chk($sformatf("t4_mem_addr_k%0d", k), mem_addr, 32'h8000_5008);
         chk($sformatf("t4_mem_wr_k%0d", k), mem_wr, 1'b1);
         chk($sformatf("t4_mem_wstrb_k%0d", k), mem_wstrb, 4'b0011);
         chk($sformatf("t4_mem_wdata_k%0d", k), mem_wdata, 32'hDEAD_BEEF);
         chk($sformatf("t4_data_ok_k%0d", k), data_data_ok, 1'b0);
      end
      next_cycle();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      sample();
      chk("t4_wait_mem_req", mem_req, 1'b0);
      next_cycle();
      mem_data_ok = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      sample();
      chk("t4_data_ok_early", data_data_ok, 1'b0);
      next_cycle();
      mem_data_ok = 1'b0;
      sample();
      chk("t4_data_ok", data_data_ok, 1'b1);
      chk("t4_data_rdata", data_rdata, 32'hA5A5_A5A5);
      next_cycle();
      sample();
      chk("t4_data_ok_once", data_data_ok, 1'b0);

      // accept and response in the same REQ cycle
      next_cycle();
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_4000;
      sample();
      chk("t6_addr_ok", data_addr_ok, 1'b1);
      next_cycle();
      data_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
      sample();
      chk("t6_mem_req", mem_req, 1'b1);
      chk("t6_data_ok_early", data_data_ok, 1'b0);
      next_cycle();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
      sample();
      chk("t6_data_ok", data_data_ok, 1'b1);
      chk("t6_data_rdata", data_rdata, 32'hCAFE_F00D);
      chk("t6_mem_req_off", mem_req, 1'b0);
      chk("t6_idle_regrant", inst_addr_ok, 1'b1);
      next_cycle();
      inst_req = 1'b0; mem_addr_ok = 1'b1;
      sample();
      chk("t6_data_ok_pulse", data_data_ok, 1'b0);
      chk("t6_inst_mem_addr", mem_addr, 32'hBFC0_0300);
      next_cycle();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_ABCD;
      sample();
      next_cycle();
      mem_data_ok = 1'b0;
      sample();
      chk("t6_inst_data_ok", inst_data_ok, 1'b1);
      chk("t6_inst_rdata", inst_rdata, 32'h1234_ABCD);

      // reset while waiting for the response; late response ignored
      next_cycle();
      inst_req = 1'b1; inst_addr = 32'hBFC0_0400;
      sample();
      chk("t5_addr_ok", inst_addr_ok, 1'b1);
      next_cycle();
      inst_req = 1'b0; mem_addr_ok = 1'b1;
      sample();
      chk("t5_mem_req", mem_req, 1'b1);
      next_cycle();
      mem_addr_ok = 1'b0; reset = 1'b1;
      sample();
      next_cycle();
      reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
      sample();
      chk("t5_data_ok_a", {inst_data_ok, data_data_ok}, 2'b00);
      chk("t5_inst_rdata_a", inst_rdata, 32'h0);
      chk("t5_data_rdata_a", data_rdata, 32'h0);
      chk("t5_mem_req", mem_req, 1'b0);
      chk("t5_mem_addr", mem_addr, 32'h0);
      next_cycle();
      mem_data_ok = 1'b0;
      sample();
      chk("t5_data_ok_b", {inst_data_ok, data_data_ok}, 2'b00);
      chk("t5_inst_rdata_b", inst_rdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
